// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: funct3 access codes,
// FSM states and common widths.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: store byte enables / lane data, load extension, and
// legality (illegal funct3 or misalignment) for one access.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic              write_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] raw_i,
  output logic [3:0]        be_c_o,
  output logic [DATA_W-1:0] wlane_c_o,
  output logic              err_c_o,
  output logic [DATA_W-1:0] rdata_c_o
);

  logic [DATA_W-1:0] shifted;
  logic              illegal;
  logic              misal;

  always_comb begin
    be_c_o    = 4'b0000;
    wlane_c_o = '0;
    rdata_c_o = '0;
    illegal   = 1'b0;
    misal     = 1'b0;
    shifted   = raw_i >> {addr_lo_i, 3'b000};

    unique case (funct3_i)
      F3_B: begin
        be_c_o    = 4'(4'b0001 << addr_lo_i);
        wlane_c_o = {4{wdata_i[7:0]}};
        rdata_c_o = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        misal     = addr_lo_i[0];
        be_c_o    = 4'(4'b0011 << addr_lo_i);
        wlane_c_o = {2{wdata_i[15:0]}};
        rdata_c_o = {{16{shifted[15]}}, shifted[15:0]};
      end
      F3_W: begin
        misal     = (addr_lo_i != 2'b00);
        be_c_o    = 4'b1111;
        wlane_c_o = wdata_i;
        rdata_c_o = raw_i;
      end
      F3_BU: begin
        illegal   = write_i;
        rdata_c_o = {24'h0, shifted[7:0]};
      end
      F3_HU: begin
        illegal   = write_i;
        misal     = addr_lo_i[0];
        rdata_c_o = {16'h0, shifted[15:0]};
      end
      default: illegal = 1'b1;
    endcase

    err_c_o = illegal | misal;
    // Errors suppress all side effects; stores return zero data.
    if (err_c_o || write_i) rdata_c_o = '0;
    if (err_c_o || !write_i) be_c_o = 4'b0000;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, programmable wait states,
// byte-banked little-endian RAM and a registered response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [7:0]        mem_q [4][DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] raw_word;
  logic [3:0]        fmt_be;
  logic [DATA_W-1:0] fmt_wlane;
  logic              fmt_err;
  logic [DATA_W-1:0] fmt_rdata;
  logic              mem_we_c;

  assign idx      = addr_q[ADDR_W-1:2];
  assign raw_word = {mem_q[3][idx], mem_q[2][idx], mem_q[1][idx], mem_q[0][idx]};

  dmem_lane_fmt u_fmt (
    .write_i   (wr_q),
    .funct3_i  (f3_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .raw_i     (raw_word),
    .be_c_o    (fmt_be),
    .wlane_c_o (fmt_wlane),
    .err_c_o   (fmt_err),
    .rdata_c_o (fmt_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          wr_d    = req_write;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          ready_d = 1'b0;
          if (WAIT_CYCLES != 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_EXEC;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_EXEC: begin
        rdata_d = fmt_rdata;
        err_d   = fmt_err;
        valid_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write lands on the EXEC edge; a coincident reset drops it.
  assign mem_we_c = (state_q == S_EXEC) && !reset && wr_q && !fmt_err;

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (fmt_be[b]) mem_q[b][idx] <= fmt_wlane[8*b +: 8];
      end
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: round trips, extension,
// alignment errors, backpressure and mid-transaction reset.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned W = 2;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction; hold > 0 keeps rsp_ready low for that many RESP cycles.
  task automatic xact(input string tag, input logic wr, input logic [2:0] f3,
                      input logic [7:0] addr, input logic [31:0] wd,
                      input logic [31:0] erd, input logic eerr, input int hold);
    int   lat;
    int   guard;
    exp_t e;
    sb_q.push_back('{rdata: erd, err: eerr});
    @(negedge clk);
    rsp_ready  = (hold == 0);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " accept"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom_range(0, 1));
    req_funct3 = 3'($urandom);
    req_addr   = 8'($urandom);
    req_wdata  = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(W + 2));
    vectors++;
    assert (sb_q.size() != 0) else begin
      miscompares++;
      $error("FAIL %s scoreboard: observed empty expected entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, " rdata"}, rsp_rdata, e.rdata);
      check({tag, " err"}, 32'(rsp_err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        check({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
        check({tag, " hold rdata"}, rsp_rdata, e.rdata);
        check({tag, " hold err"}, 32'(rsp_err), 32'(e.err));
        check({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
      end
    end
    if (hold > 0) begin
      @(negedge clk);
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " valid clear"}, 32'(rsp_valid), 32'd0);
    check({tag, " ready back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stray;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 8'h00;
    req_wdata  = 32'h0;
    rsp_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst req_ready", 32'(req_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'h0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    xact("sw10", 1'b1, F3_W, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    xact("lw10", 1'b0, F3_W, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

    xact("sw20",  1'b1, F3_W,  8'h20, 32'h80FF7F01, 32'h0, 1'b0, 0);
    xact("lb23",  1'b0, F3_B,  8'h23, 32'h0, 32'hFFFFFF80, 1'b0, 0);
    xact("lbu23", 1'b0, F3_BU, 8'h23, 32'h0, 32'h00000080, 1'b0, 0);
    xact("lh22",  1'b0, F3_H,  8'h22, 32'h0, 32'hFFFF80FF, 1'b0, 0);
    xact("lhu22", 1'b0, F3_HU, 8'h22, 32'h0, 32'h000080FF, 1'b0, 0);
    xact("lb20",  1'b0, F3_B,  8'h20, 32'h0, 32'h00000001, 1'b0, 0);
    xact("lb21",  1'b0, F3_B,  8'h21, 32'h0, 32'h0000007F, 1'b0, 0);

    xact("sb21",   1'b1, F3_B,  8'h21, 32'h123456AA, 32'h0, 1'b0, 0);
    xact("lw20a",  1'b0, F3_W,  8'h20, 32'h0, 32'h80FFAA01, 1'b0, 0);
    xact("sh21",   1'b1, F3_H,  8'h21, 32'h0000BEEF, 32'h0, 1'b1, 0);
    xact("sbu20",  1'b1, F3_BU, 8'h20, 32'h000000EE, 32'h0, 1'b1, 0);
    xact("lw20b",  1'b0, F3_W,  8'h20, 32'h0, 32'h80FFAA01, 1'b0, 0);
    xact("lw22",   1'b0, F3_W,  8'h22, 32'h0, 32'h0, 1'b1, 0);
    xact("lh21",   1'b0, F3_H,  8'h21, 32'h0, 32'h0, 1'b1, 0);
    xact("sh22",   1'b1, F3_H,  8'h22, 32'hFFFF1234, 32'h0, 1'b0, 0);
    xact("lw20c",  1'b0, F3_W,  8'h20, 32'h0, 32'h1234AA01, 1'b0, 0);

    xact("lw10bp", 1'b0, F3_W,  8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);
    xact("ld011",  1'b0, 3'b011, 8'h10, 32'h0, 32'h0, 1'b1, 0);

    // Reset during WAIT of a store must drop it without a response.
    xact("sw30", 1'b1, F3_W, 8'h30, 32'h0BADF00D, 32'h0, 1'b0, 0);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 8'h30;
    req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst req_ready", 32'(req_ready), 32'd1);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    stray = 0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (rsp_valid) stray++;
    end
    check("midrst stray rsp", 32'(stray), 32'd0);
    xact("lw30", 1'b0, F3_W, 8'h30, 32'h0, 32'h0BADF00D, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
